prefetch: RTL

PREFETCH -- requirements
Module: prefetch

---
 rtl/prefetch.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/prefetch.sv
`default_nettype none
// ============================================================================
// Module      : prefetch
// Description : Instruction prefetch unit. Issues sequential fetches under a
//               credit limit, tags each request with its PC, and queues the
//               returned words for decode. Redirects flush the queue and drop
//               responses that were still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module prefetch #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [XLEN-1:0] BOOT_ADDR = '0,
    parameter logic [31:0]     NOP       = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_ir,
    output logic            misaligned
);

    // Pointer width for DEPTH entries, counter width able to hold DEPTH.
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] fetch_pc_q,    fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q,        drop_d;
    logic            misaligned_q,  misaligned_d;
    logic [CW-1:0]   q_count_q,     q_count_d;
    logic [PW-1:0]   q_wr_q,        q_wr_d;
    logic [PW-1:0]   q_rd_q,        q_rd_d;
    logic [PW-1:0]   tag_wr_q,      tag_wr_d;
    logic [PW-1:0]   tag_rd_q,      tag_rd_d;

    // Storage arrays (no reset needed; validity is tracked by the counters).
    logic [XLEN-1:0] tag_mem_q  [DEPTH];
    logic [XLEN-1:0] q_pc_mem_q [DEPTH];
    logic [31:0]     q_ir_mem_q [DEPTH];

    // ------------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------------
    logic          req_fire;
    logic          rsp_fire;
    logic          rsp_drop;
    logic          q_push;
    logic          q_pop;
    logic          credit_ok;
    logic [CW:0]   in_use;

    // Occupancy seen by the credit rule: queued plus still-in-flight words.
    assign in_use    = {1'b0, q_count_q} + {1'b0, outstanding_q};
    assign credit_ok = (in_use < (CW + 1)'(DEPTH));

    assign imem_req_valid = resetn & ~redirect & ~misaligned_q & credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_fire = resetn & imem_rsp_valid & (outstanding_q != '0);
    assign rsp_drop = rsp_fire & (drop_q != '0);
    assign q_push   = rsp_fire & ~rsp_drop & ~redirect;
    assign q_pop    = resetn & (q_count_q != '0) & out_ready & ~redirect;

    assign out_valid  = (q_count_q != '0);
    assign out_pc     = q_pc_mem_q[q_rd_q];
    assign out_ir     = out_valid ? q_ir_mem_q[q_rd_q] : NOP;
    assign misaligned = misaligned_q;

    // Next-state computation; redirect overrides normal flow, reset overrides all.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        misaligned_d  = misaligned_q;
        q_count_d     = q_count_q;
        q_wr_d        = q_wr_q;
        q_rd_d        = q_rd_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            tag_wr_d   = tag_wr_q + PW'(1);
        end

        // Every counted response retires one tag, dropped or not.
        if (rsp_fire) begin
            tag_rd_d = tag_rd_q + PW'(1);
        end

        unique case ({req_fire, rsp_fire})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (rsp_drop) begin
            drop_d = drop_q - CW'(1);
        end

        if (q_push) begin
            q_wr_d = q_wr_q + PW'(1);
        end
        if (q_pop) begin
            q_rd_d = q_rd_q + PW'(1);
        end

        unique case ({q_push, q_pop})
            2'b10:   q_count_d = q_count_q + CW'(1);
            2'b01:   q_count_d = q_count_q - CW'(1);
            default: q_count_d = q_count_q;
        endcase

        // Flush the queue; everything still in flight must be discarded on return.
        if (redirect) begin
            fetch_pc_d   = redirect_pc;
            q_count_d    = '0;
            q_wr_d       = '0;
            q_rd_d       = '0;
            drop_d       = outstanding_d;
            misaligned_d = (redirect_pc[1:0] != 2'b00);
        end

        if (!resetn) begin
            fetch_pc_d    = BOOT_ADDR;
            outstanding_d = '0;
            drop_d        = '0;
            misaligned_d  = 1'b0;
            q_count_d     = '0;
            q_wr_d        = '0;
            q_rd_d        = '0;
            tag_wr_d      = '0;
            tag_rd_d      = '0;
        end
    end

    // Control registers update on every rising edge.
    always_ff @(posedge clk) begin
        fetch_pc_q    <= fetch_pc_d;
        outstanding_q <= outstanding_d;
        drop_q        <= drop_d;
        misaligned_q  <= misaligned_d;
        q_count_q     <= q_count_d;
        q_wr_q        <= q_wr_d;
        q_rd_q        <= q_rd_d;
        tag_wr_q      <= tag_wr_d;
        tag_rd_q      <= tag_rd_d;
    end

    // Record the PC of each accepted request in issue order.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem_q[tag_wr_q] <= fetch_pc_q;
        end
    end

    // Capture a kept response together with its tagged PC.
    always_ff @(posedge clk) begin
        if (q_push) begin
            q_pc_mem_q[q_wr_q] <= tag_mem_q[tag_rd_q];
            q_ir_mem_q[q_wr_q] <= imem_rsp_data;
        end
    end

endmodule
`default_nettype wire
